perf_uart_tx: RTL and testbench
===============================

// Module: perf_uart_tx
// PURPOSE
//  Reader/transmitter for the core's performance-counter outputs: clk_cycles, retired_instructions,
//  predictions_made, correct_predictions and invalid_clk_cycles.
//  On a start pulse it snapshots all five counters, then serialises them as a fixed 14-byte frame
//  over a UART 8N1 line to the host. Sits beside the pipeline top and is its only off-chip reporting path.
// PARAMETERS
//  CLKS_PER_BIT  651   clk cycles per UART bit (75 MHz / 115200); legal range 2..65535
//  SYNC_BYTE     8'hA5 first byte of every frame
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   single-cycle request: snapshot counters and send one frame
//  clk_cycles   in   28  cycle counter from core
//  retired      in   13  retired-instruction counter
//  pred_made    in   13  branch predictions made
//  pred_correct in   13  correct branch predictions
//  invalid_cyc  in   13  invalid-instruction cycles
//  tx           out  1   UART serial line, idle high
//  busy         out  1   high from start acceptance until frame end
//  done         out  1   one-cycle pulse when the final stop bit completes
// BEHAVIOUR
//  Reset (async, rst_n=0): tx=1, busy=0, done=0, FSM=IDLE, snapshot cleared. Takes effect immediately, including mid-frame.
//  Accept: start=1 while busy=0 in IDLE.
//   - On that edge, latch all counters into the snapshot; busy=1; FSM->START.
//   - start while busy=1 is ignored; no queueing.
//  Frame, 14 bytes, in order:
//   - byte 0: SYNC_BYTE
//   - bytes 1-4: clk_cycles, zero-extended to 32 bits, little-endian
//   - bytes 5-6: retired; 7-8: pred_made; 9-10: pred_correct; 11-12: invalid_cyc.
//     Each zero-extended to 16 bits, little-endian.
//   - byte 13: XOR of bytes 1..12 (sync byte excluded)
//  Byte format: start bit 0, data bits 0..7 LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
//   - Bytes are back-to-back; there are no idle bits between bytes.
//  FSM: IDLE -> START -> DATA(8 bits) -> STOP -> START (next byte) or DONE -> IDLE.
//   - Transitions happen when the baud counter reaches CLKS_PER_BIT-1; the counter then reloads 0.
//   - byte_idx runs 0..13. After STOP of byte 13, FSM goes to DONE.
//   - DONE lasts 1 cycle: done=1, busy=0, tx=1. Next cycle FSM returns to IDLE.
//   - A start seen in the DONE cycle is ignored.
//  Latency: tx falls on the first cycle after the accept edge.
//   - Full frame = 140*CLKS_PER_BIT cycles of line activity; done asserts the following cycle.
//  Counter inputs may change at any time during a frame; the transmitted values are the snapshot only.
//  Checksum is accumulated from snapshot bytes; no dependence on live inputs.
//  tx is driven from a register (glitch-free); busy and done are registered.
// TESTING (bench uses CLKS_PER_BIT=4)
//  1. Reset: hold rst_n=0, then release -> tx=1, busy=0, done=0.
//     Drive rst_n=0 for 1 cycle mid-bit -> tx=1 asynchronously, busy=0.
//  2. Frame content: clk_cycles=28'h0ABCDEF, retired=13'h1234, pred_made=13'h0100, pred_correct=13'h00FF,
//     invalid_cyc=0, pulse start -> decoded bytes A5 EF CD AB 00 34 12 00 01 FF 00 00 00 51.
//  3. Timing: from the start edge, the tx low edge is 1 cycle later.
//     done pulses exactly 560 cycles after the first tx low; busy is high for those 560 cycles plus 1.
//  4. Snapshot isolation: rewrite all counters to 13'h1FFF / 28'hFFFFFFF at byte 3 -> frame identical to test 2.
//  5. Start while busy: pulse start at byte 6 -> ignored; only one frame and one done.
//     Then pulse start at the done cycle -> ignored.
//     Pulse start one cycle after done -> second frame begins.
//  6. Max values: all counters at max -> bytes A5 FF FF FF 0F FF 1F FF 1F FF 1F FF 1F F0.
//     Verify each stop bit=1 and no inter-byte gap.

Source files
------------

// File: rtl/perf_uart_tx_if.sv
// Handshake/data bundle between the core's counter block and the perf-counter UART reporter.
// The master drives the request and the counters; the slave drives the line and the status flags.
interface perf_uart_tx_if;
  logic        start;
  logic [27:0] clk_cycles;
  logic [12:0] retired;
  logic [12:0] pred_made;
  logic [12:0] pred_correct;
  logic [12:0] invalid_cyc;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output start, clk_cycles, retired, pred_made, pred_correct, invalid_cyc,
    input  tx, busy, done
  );

  modport slave (
    input  start, clk_cycles, retired, pred_made, pred_correct, invalid_cyc,
    output tx, busy, done
  );
endinterface

// File: rtl/perf_uart_tx.sv
// Snapshots the five performance counters on start and sends them as a 14-byte
// 8N1 frame: sync, clk_cycles (32b LE), four 16b LE counters, XOR checksum.
module perf_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 651,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  perf_uart_tx_if.slave  bus
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_START = 3'd1;
  localparam logic [2:0]  S_DATA  = 3'd2;
  localparam logic [2:0]  S_STOP  = 3'd3;
  localparam logic [2:0]  S_DONE  = 3'd4;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd13;

  typedef struct packed {
    logic [27:0] clk_cycles;
    logic [12:0] retired;
    logic [12:0] pred_made;
    logic [12:0] pred_correct;
    logic [12:0] invalid_cyc;
  } snap_t;

  logic [2:0]   state_q, state_d;
  logic [15:0]  baud_q, baud_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [3:0]   byte_idx_q, byte_idx_d;
  snap_t        snap_q, snap_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         accept;
  logic         baud_tick;
  logic [95:0]  payload;
  logic [7:0]   checksum;
  logic [111:0] frame;
  logic [7:0]   cur_byte;

  // Payload bytes 1..12 sit LSB-first so byte k lives at payload[8*(k-1) +: 8].
  always_comb begin
    payload = {16'(snap_q.invalid_cyc), 16'(snap_q.pred_correct),
               16'(snap_q.pred_made),   16'(snap_q.retired),
               32'(snap_q.clk_cycles)};
    checksum = '0;
    for (int i = 0; i < 12; i++) checksum ^= payload[8*i +: 8];
    frame    = {checksum, payload, SYNC_BYTE};
    cur_byte = frame[{byte_idx_q, 3'b000} +: 8];
  end

  // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    snap_d     = snap_q;

    baud_tick = (baud_q == BAUD_LAST);
    // The done cycle is excluded so a start coinciding with the done pulse is dropped.
    accept    = bus.start && !busy_q && !done_q && (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_START;
          baud_d     = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          snap_d     = '{clk_cycles:   bus.clk_cycles,
                         retired:      bus.retired,
                         pred_made:    bus.pred_made,
                         pred_correct: bus.pred_correct,
                         invalid_cyc:  bus.invalid_cyc};
        end
      end
      S_START, S_DATA, S_STOP: begin
        baud_d = baud_tick ? '0 : baud_q + 16'd1;
        if (baud_tick) begin
          case (state_q)
            S_START: begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end
            S_DATA: begin
              if (bit_idx_q == 3'd7) state_d = S_STOP;
              else                   bit_idx_d = bit_idx_q + 3'd1;
            end
            default: begin
              if (byte_idx_q == LAST_BYTE) begin
                state_d = S_DONE;
              end else begin
                state_d    = S_START;
                byte_idx_d = byte_idx_q + 4'd1;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the current state, so the line lags the FSM by one cycle.
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
    busy_d = accept || (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    done_d = (state_q == S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the snapshot is reset too; it is a handful of flops, not a RAM, and a cleared value keeps the checksum deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      snap_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      snap_q     <= snap_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_perf_uart_tx.sv
// Self-checking bench for perf_uart_tx: a frame-level reference model compared every cycle,
// plus a UART receiver whose decoded bytes are checked against hand-computed frames.
module tb_perf_uart_tx;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = 140 * CPB;
  localparam logic [111:0] FRAME_T2  = 112'hA5EFCDAB0034120001FF00000051;
  localparam logic [111:0] FRAME_MAX = 112'hA5FFFFFF0FFF1FFF1FFF1FFF1FF0;

  logic clk = 1'b0;
  logic rst_n;

  perf_uart_tx_if bus ();

  perf_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: byte list from the counter values, expanded to the 140-bit line sequence.
  function automatic logic [139:0] frame_bits(input logic [27:0] c, input logic [12:0] r,
                                              input logic [12:0] pm, input logic [12:0] pc,
                                              input logic [12:0] iv);
    logic [7:0]   b [14];
    logic [139:0] bits;
    logic [31:0]  c32;
    c32  = 32'(c);
    b[0] = 8'hA5;
    for (int k = 0; k < 4; k++) b[1+k] = 8'(c32 >> (8*k));
    b[5]  = 8'(r);  b[6]  = 8'(16'(r)  >> 8);
    b[7]  = 8'(pm); b[8]  = 8'(16'(pm) >> 8);
    b[9]  = 8'(pc); b[10] = 8'(16'(pc) >> 8);
    b[11] = 8'(iv); b[12] = 8'(16'(iv) >> 8);
    b[13] = 8'h00;
    for (int k = 1; k <= 12; k++) b[13] = b[13] ^ b[k];
    for (int k = 0; k < 14; k++) begin
      bits[10*k] = 1'b0;
      for (int i = 0; i < 8; i++) bits[10*k+1+i] = b[k][i];
      bits[10*k+9] = 1'b1;
    end
    return bits;
  endfunction

  // Model: m_k counts edges since the accept edge; outputs follow from that count alone.
  logic [139:0] m_bits;
  int           m_k;
  bit           m_ever;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ever <= 1'b0;
      m_k    <= 0;
      m_bits <= '1;
    end else if (bus.start && (!m_ever || m_k >= FRAME_CYC + 2)) begin
      m_bits <= frame_bits(bus.clk_cycles, bus.retired, bus.pred_made,
                           bus.pred_correct, bus.invalid_cyc);
      m_k    <= 0;
      m_ever <= 1'b1;
    end else if (m_ever && m_k < 100000) begin
      m_k <= m_k + 1;
    end
  end

  always @(posedge clk) begin
    logic exp_tx, exp_busy, exp_done;
    #1;
    exp_busy = m_ever && (m_k <= FRAME_CYC);
    exp_done = m_ever && (m_k == FRAME_CYC + 1);
    exp_tx   = (m_ever && m_k >= 1 && m_k <= FRAME_CYC) ? m_bits[(m_k-1)/CPB] : 1'b1;
    check("tx",   32'(bus.tx),   32'(exp_tx));
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("done", 32'(bus.done), 32'(exp_done));
    if (bus.done === 1'b1) done_cnt++;
  end

  // Mid-bit sampling receiver.
  logic [7:0] rx_q [$];
  bit         rx_stop [$];

  initial begin : rx_proc
    logic [7:0] b;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && bus.tx === 1'b0) begin
        repeat (CPB/2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          b[i] = bus.tx;
        end
        repeat (CPB) @(posedge clk);
        rx_q.push_back(b);
        rx_stop.push_back(bus.tx);
      end
    end
  end

  task automatic set_counters(input logic [27:0] c, input logic [12:0] r, input logic [12:0] pm,
                              input logic [12:0] pc, input logic [12:0] iv);
    bus.clk_cycles   = c;
    bus.retired      = r;
    bus.pred_made    = pm;
    bus.pred_correct = pc;
    bus.invalid_cyc  = iv;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [111:0] exp);
    check({name, "_len"}, 32'(rx_q.size()), 32'd14);
    for (int i = 0; i < 14 && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp[111-8*i -: 8]));
      check($sformatf("%s_stop%0d", name, i), 32'(rx_stop[i]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_low, t_done, n_busy, d0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    set_counters(28'h0, 13'h0, 13'h0, 13'h0, 13'h0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(bus.tx),   32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx",   32'(bus.tx),   32'd1);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of byte 1's start bit
    set_counters(28'h0ABCDEF, 13'h1234, 13'h0100, 13'h00FF, 13'h0000);
    pulse_start();
    repeat (42) @(negedge clk);
    check("mid_tx_low", 32'(bus.tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx",   32'(bus.tx),   32'd1);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rx_q.delete();
    rx_stop.delete();

    // Frame content and timing
    t_low  = -1;
    t_done = -1;
    n_busy = 0;
    bus.start = 1'b1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (t_low < 0 && bus.tx === 1'b0) t_low = k;
      if (bus.done === 1'b1) begin
        t_done = k;
        break;
      end
      if (bus.busy === 1'b1) n_busy++;
    end
    check("tx_low_latency", 32'(t_low), 32'd1);
    check("done_after_low", 32'(t_done - t_low), 32'd560);
    check("busy_cycles",    32'(n_busy), 32'd561);
    check_frame("t2", FRAME_T2);
    repeat (5) @(negedge clk);

    // Snapshot isolation
    rx_q.delete();
    rx_stop.delete();
    pulse_start();
    repeat (130) @(negedge clk);
    set_counters(28'hFFFFFFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF);
    wait_done("snap");
    check_frame("snap", FRAME_T2);
    repeat (5) @(negedge clk);

    // Start while busy, and start in the done cycle
    set_counters(28'h0ABCDEF, 13'h1234, 13'h0100, 13'h00FF, 13'h0000);
    rx_q.delete();
    rx_stop.delete();
    d0 = done_cnt;
    pulse_start();
    repeat (259) @(negedge clk);
    pulse_start();
    wait_done("busy_start");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check_frame("busy_start", FRAME_T2);

    // Max values, then a start one cycle after done
    set_counters(28'hFFFFFFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF);
    rx_q.delete();
    rx_stop.delete();
    pulse_start();
    wait_done("max");
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_after_done", 32'(bus.busy), 32'd1);
    check_frame("max", FRAME_MAX);
    rx_q.delete();
    rx_stop.delete();
    wait_done("max2");
    check_frame("max2", FRAME_MAX);
    check("total_dones", 32'(done_cnt - d0), 32'd3);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
